// File: rtl/lsq_mem_sequencer.sv
// lsq_mem_sequencer: sequencer between the load/store queue head and the single data-memory port.
// It pops one ready LSQ entry and forms the effective address, byte masks and lane-shifted store
// data. It then runs one dmem transaction and broadcasts the load result (or store completion)
// on the CDB. Only one memory operation is in flight at a time, and a flush during a transaction
// lets the transaction drain without a broadcast.
//
// Optional feature: define LSQ_MISALIGN_TRAP_EN to add output cdb_exception. Misaligned
// half/word accesses then skip memory and broadcast the faulting address with cdb_exception=1.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush                    synchronous pipeline flush
//   lsq_empty                LSQ has no entry
//   lsq_read_enable          pop request to the LSQ
//   lsq_read_resp, lsq_data  popped entry, valid one cycle after the pop
//   rs1_rdata, rs2_rdata     base address / store data for the entry
//   dmem_addr/rmask/wmask/wdata/rdata/resp   data memory port
//   cdb_valid/phys_rd/rob_index/rdata        common data bus broadcast
//   cdb_exception            misalignment trap flag (LSQ_MISALIGN_TRAP_EN only)
//   busy                     sequencer not idle

package lsq_mem_pkg;
  // Field widths match the default NUM_REGS=64 / ROB_SIZE=32 configuration.
  localparam int unsigned LsqPhysW = 6;
  localparam int unsigned LsqRobW  = 5;

  typedef struct packed {
    logic                is_store;
    logic [2:0]          funct3;
    logic [11:0]         imm;
    logic [LsqPhysW-1:0] phys_rd;
    logic [LsqRobW-1:0]  rob_index;
  } ld_st_queue_t;
endpackage

module lsq_mem_sequencer #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned ROB_SIZE = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          lsq_empty,
  output logic                          lsq_read_enable,
  input  logic                          lsq_read_resp,
  input  lsq_mem_pkg::ld_st_queue_t     lsq_data,
  input  logic [31:0]                   rs1_rdata,
  input  logic [31:0]                   rs2_rdata,
  output logic [31:0]                   dmem_addr,
  output logic [3:0]                    dmem_rmask,
  output logic [3:0]                    dmem_wmask,
  output logic [31:0]                   dmem_wdata,
  input  logic [31:0]                   dmem_rdata,
  input  logic                          dmem_resp,
  output logic                          cdb_valid,
  output logic [$clog2(NUM_REGS)-1:0]   cdb_phys_rd,
  output logic [$clog2(ROB_SIZE)-1:0]   cdb_rob_index,
  output logic [31:0]                   cdb_rdata,
`ifdef LSQ_MISALIGN_TRAP_EN
  output logic                          cdb_exception,
`endif
  output logic                          busy
);

  localparam int unsigned PhysW = $clog2(NUM_REGS);
  localparam int unsigned RobW  = $clog2(ROB_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain,
    StBcast
  } state_e;

  state_e                    state_q, state_d;
  lsq_mem_pkg::ld_st_queue_t entry_q, entry_d;
  logic [31:0]               rs1_q, rs1_d;
  logic [31:0]               rs2_q, rs2_d;
  logic [31:0]               addr_q, addr_d;
  logic [3:0]                rmask_q, rmask_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [1:0]                off_q, off_d;
  logic [31:0]               rdata_q, rdata_d;
`ifdef LSQ_MISALIGN_TRAP_EN
  logic                      exc_q, exc_d;
  logic                      misaligned;
`endif

  logic [31:0] eff_addr;
  logic [1:0]  off;
  logic [3:0]  acc_mask;
  logic [31:0] store_data;
  logic [31:0] lane;
  logic [31:0] load_val;

  // Address generation and lane placement, evaluated while in StIssue.
  assign eff_addr   = rs1_q + {{20{entry_q.imm[11]}}, entry_q.imm};
  assign off        = eff_addr[1:0];
  assign store_data = rs2_q << {off, 3'b000};

  // Shifted masks are 4 bits wide, so a misaligned half/word simply loses its upper lanes.
  always_comb begin
    case (entry_q.funct3[1:0])
      2'b00:   acc_mask = 4'b0001 << off;
      2'b01:   acc_mask = 4'b0011 << off;
      default: acc_mask = 4'b1111;
    endcase
  end

`ifdef LSQ_MISALIGN_TRAP_EN
  assign misaligned = ((entry_q.funct3[1:0] == 2'b01) && off[0]) ||
                      (entry_q.funct3[1] && (off != 2'b00));
`endif

  // Load extraction uses the byte offset captured at issue time.
  assign lane = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (entry_q.funct3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    addr_d  = addr_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    rdata_d = rdata_q;
`ifdef LSQ_MISALIGN_TRAP_EN
    exc_d   = exc_q;
`endif

    case (state_q)
      StIdle: begin
        // A flush coinciding with the LSQ response discards the entry.
        if (lsq_read_resp && !flush) begin
          entry_d = lsq_data;
          rs1_d   = rs1_rdata;
          rs2_d   = rs2_rdata;
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          off_d  = off;
          addr_d = {eff_addr[31:2], 2'b00};
`ifdef LSQ_MISALIGN_TRAP_EN
          exc_d  = 1'b0;
          if (misaligned) begin
            // Report the faulting address instead of touching memory.
            exc_d   = 1'b1;
            rdata_d = eff_addr;
            state_d = StBcast;
          end else
`endif
          begin
            rmask_d = entry_q.is_store ? 4'b0000 : acc_mask;
            wmask_d = entry_q.is_store ? acc_mask : 4'b0000;
            wdata_d = entry_q.is_store ? store_data : 32'h0;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (dmem_resp) begin
          rmask_d = 4'b0000;
          wmask_d = 4'b0000;
          rdata_d = entry_q.is_store ? 32'h0 : load_val;
          state_d = flush ? StIdle : StBcast;
        end else if (flush) begin
          state_d = StDrain;
        end
      end

      // The memory transaction cannot be cancelled; hold the request until it completes.
      StDrain: begin
        if (dmem_resp) begin
          rmask_d = 4'b0000;
          wmask_d = 4'b0000;
          state_d = StIdle;
        end
      end

      StBcast: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      entry_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
`ifdef LSQ_MISALIGN_TRAP_EN
      exc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
`ifdef LSQ_MISALIGN_TRAP_EN
      exc_q   <= exc_d;
`endif
    end
  end

  // A response in hand means the entry for this cycle is already popped, so do not request
  // another. The reset term keeps the pop request low while reset is asserted.
  assign lsq_read_enable = rst && (state_q == StIdle) && !lsq_empty && !lsq_read_resp;

  assign busy          = (state_q != StIdle);
  assign cdb_valid     = (state_q == StBcast) && !flush;
  assign cdb_phys_rd   = PhysW'(entry_q.phys_rd);
  assign cdb_rob_index = RobW'(entry_q.rob_index);
  assign cdb_rdata     = rdata_q;
  assign dmem_addr     = addr_q;
  assign dmem_rmask    = rmask_q;
  assign dmem_wmask    = wmask_q;
  assign dmem_wdata    = wdata_q;
`ifdef LSQ_MISALIGN_TRAP_EN
  assign cdb_exception = exc_q && cdb_valid;
`endif

endmodule

// File: tb/tb_lsq_mem_sequencer.sv
// Self-checking bench for lsq_mem_sequencer: directed cases plus randomized operations checked
// against a behavioural model of address, mask, store-lane and load-extension rules.
module tb_lsq_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        lsq_empty;
  logic        lsq_read_enable;
  logic        lsq_read_resp;
  logic [26:0] lsq_data;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_resp;
  logic        cdb_valid;
  logic [5:0]  cdb_phys_rd;
  logic [4:0]  cdb_rob_index;
  logic [31:0] cdb_rdata;
  logic        busy;
`ifdef LSQ_MISALIGN_TRAP_EN
  logic        cdb_exception;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam int FlNone  = -1;
  localparam int FlIssue = 0;
  localparam int FlBcast = 100;
  localparam int FlResp  = 200;
  localparam int RstWait = 300;

  lsq_mem_sequencer #(
    .NUM_REGS(64),
    .ROB_SIZE(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .lsq_empty      (lsq_empty),
    .lsq_read_enable(lsq_read_enable),
    .lsq_read_resp  (lsq_read_resp),
    .lsq_data       (lsq_data),
    .rs1_rdata      (rs1_rdata),
    .rs2_rdata      (rs2_rdata),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .cdb_valid      (cdb_valid),
    .cdb_phys_rd    (cdb_phys_rd),
    .cdb_rob_index  (cdb_rob_index),
    .cdb_rdata      (cdb_rdata),
`ifdef LSQ_MISALIGN_TRAP_EN
    .cdb_exception  (cdb_exception),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One LSQ operation end to end. flush_at: FlNone, FlIssue, WAIT cycle k (1..lat), FlBcast,
  // FlResp (flush with the LSQ response) or RstWait (async reset in WAIT cycle 2).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [11:0] imm,
                        input logic [31:0] rs1v, input logic [31:0] rs2v,
                        input logic [31:0] memv, input int lat, input int refuse,
                        input int flush_at);
    logic [31:0] ea, wd, lane, res;
    logic [3:0]  m, exp_r, exp_w;
    logic [5:0]  pr;
    logic [4:0]  rob;
    int          off, nbytes;
    bit          mis, flushed;
    // Reference model.
    ea     = rs1v + 32'($signed(imm));
    off    = int'(ea % 4);
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    m      = (nbytes == 4) ? 4'hF : 4'(((1 << nbytes) - 1) << off);
    mis    = (nbytes == 2 && (off % 2) != 0) || (nbytes == 4 && off != 0);
    wd     = rs2v << (8 * off);
    lane   = memv >> (8 * off);
    if (nbytes == 1) res = lane & 32'hFF;
    else if (nbytes == 2) res = lane & 32'hFFFF;
    else res = lane;
    if (f3 == 3'b000 && res[7]) res = res | 32'hFFFF_FF00;
    if (f3 == 3'b001 && res[15]) res = res | 32'hFFFF_0000;
    if (st) res = 32'h0;
    exp_r  = st ? 4'h0 : m;
    exp_w  = st ? m : 4'h0;
    pr     = 6'($urandom);
    rob    = 5'($urandom);
    flushed = 1'b0;

    @(posedge clk); #1;
    lsq_empty = 1'b0;
    for (int r = 0; r <= refuse; r++) begin
      @(negedge clk);
      check_eq("pop_req", {31'h0, lsq_read_enable}, 32'h1);
      @(posedge clk); #1;
    end
    lsq_read_resp = 1'b1;
    lsq_data      = {st, f3, imm, pr, rob};
    rs1_rdata     = rs1v;
    rs2_rdata     = rs2v;
    lsq_empty     = 1'b1;
    flush         = (flush_at == FlResp);
    @(posedge clk); #1;
    lsq_read_resp = 1'b0;
    lsq_data      = 27'($urandom);
    rs1_rdata     = $urandom;
    rs2_rdata     = $urandom;
    flush         = 1'b0;
    if (flush_at == FlResp) begin
      @(negedge clk);
      check_eq("resp_flush_idle", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("resp_flush_nomask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
      return;
    end
    // ISSUE cycle.
    flush = (flush_at == FlIssue);
    @(negedge clk);
    check_eq("issue_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    if (flush_at == FlIssue) begin
      @(negedge clk);
      check_eq("issue_flush_nomask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
      check_eq("issue_flush_idle", {31'h0, busy | cdb_valid}, 32'h0);
      return;
    end
`ifdef LSQ_MISALIGN_TRAP_EN
    if (mis) begin
      flush = (flush_at == FlBcast);
      @(negedge clk);
      check_eq("trap_nomask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
      check_eq("trap_valid", {31'h0, cdb_valid}, {31'h0, flush_at != FlBcast});
      check_eq("trap_exc", {31'h0, cdb_exception}, {31'h0, flush_at != FlBcast});
      if (flush_at != FlBcast) check_eq("trap_addr", cdb_rdata, ea);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_eq("trap_done", {30'h0, cdb_valid, busy}, 32'h0);
      return;
    end
`endif
    // WAIT (or DRAIN after a flush) for lat cycles, response in the last one.
    for (int c = 1; c <= lat; c++) begin
      dmem_resp  = (c == lat);
      dmem_rdata = (c == lat) ? memv : $urandom;
      flush      = (c == flush_at);
      if (c == flush_at) flushed = 1'b1;
      if (flush_at == RstWait && c == 2) begin
        dmem_resp = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_mask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        check_eq("arst_addr", dmem_addr, 32'h0);
        check_eq("arst_ctl", {29'h0, busy, cdb_valid, lsq_read_enable}, 32'h0);
        lsq_empty = 1'b0;
        #1;
        check_eq("arst_noreq", {31'h0, lsq_read_enable}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("arst_rel_busy", {31'h0, busy}, 32'h0);
        check_eq("arst_rel_req", {31'h0, lsq_read_enable}, 32'h1);
        lsq_empty = 1'b1;
        #1;
        check_eq("arst_rel_noreq", {31'h0, lsq_read_enable}, 32'h0);
        return;
      end
      @(negedge clk);
      check_eq("dmem_addr", dmem_addr, {ea[31:2], 2'b00});
      check_eq("dmem_rmask", {28'h0, dmem_rmask}, {28'h0, exp_r});
      check_eq("dmem_wmask", {28'h0, dmem_wmask}, {28'h0, exp_w});
      if (st) check_eq("dmem_wdata", dmem_wdata, wd);
      @(posedge clk); #1;
    end
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    flush      = (flush_at == FlBcast);
    @(negedge clk);
    check_eq("done_mask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
    if (flushed) begin
      check_eq("flush_no_bcast", {30'h0, cdb_valid, busy}, 32'h0);
    end else begin
      check_eq("cdb_valid", {31'h0, cdb_valid}, {31'h0, flush_at != FlBcast});
      if (flush_at != FlBcast) begin
        check_eq("cdb_rdata", cdb_rdata, res);
        check_eq("cdb_tags", {21'h0, cdb_phys_rd, cdb_rob_index}, {21'h0, pr, rob});
`ifdef LSQ_MISALIGN_TRAP_EN
        check_eq("cdb_exc_clear", {31'h0, cdb_exception}, 32'h0);
`endif
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("post_idle", {30'h0, cdb_valid, busy}, 32'h0);
  endtask

  initial begin
    int      mode, lat;
    logic [2:0] f3;
    logic       st;
    rst = 1'b0; flush = 1'b0; lsq_empty = 1'b0; lsq_read_resp = 1'b0; lsq_data = '0;
    rs1_rdata = '0; rs2_rdata = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctl", {29'h0, busy, cdb_valid, lsq_read_enable}, 32'h0);
    check_eq("reset_mask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
    check_eq("reset_cdb", cdb_rdata | dmem_addr | dmem_wdata, 32'h0);
    lsq_empty = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases.
    run_op(1'b0, 3'b010, 12'd8, 32'h1000, 32'h0, 32'hDEADBEEF, 3, 0, FlNone);
    run_op(1'b0, 3'b000, 12'd3, 32'h1000, 32'h0, 32'h80FFFFFF, 2, 1, FlNone);
    run_op(1'b0, 3'b100, 12'd3, 32'h1000, 32'h0, 32'h80FFFFFF, 1, 0, FlNone);
    run_op(1'b1, 3'b001, 12'd2, 32'h2000, 32'h0000ABCD, 32'h0, 2, 0, FlNone);
    run_op(1'b0, 3'b010, 12'd4, 32'h3000, 32'h0, 32'h12345678, 5, 0, 2);
    run_op(1'b0, 3'b101, 12'd2, 32'h3000, 32'h0, 32'h8765CAFE, 2, 0, FlNone);
    run_op(1'b0, 3'b010, 12'd0, 32'h4000, 32'h0, 32'h0, 5, 0, RstWait);
    run_op(1'b0, 3'b010, 12'd2, 32'h1000, 32'h0, 32'hA5A5A5A5, 2, 0, FlNone);
    run_op(1'b0, 3'b001, 12'hFFC, 32'h0, 32'h0, 32'h8001_0000, 1, 0, FlNone);
    run_op(1'b1, 3'b000, 12'd1, 32'h10, 32'h1234_56EE, 32'h0, 2, 0, FlIssue);
    run_op(1'b1, 3'b010, 12'd0, 32'h10, 32'h1234_56EE, 32'h0, 3, 0, 3);
    run_op(1'b0, 3'b000, 12'd5, 32'h20, 32'h0, 32'h00C3_0000, 2, 0, FlBcast);
    run_op(1'b0, 3'b010, 12'd0, 32'h30, 32'h0, 32'h1, 2, 0, FlResp);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if (f3 == 3'b011) f3 = 3'b010;
      lat  = $urandom_range(1, 4);
      mode = $urandom_range(0, 9);
      run_op(st, f3, 12'($urandom), $urandom, $urandom, $urandom, lat,
             $urandom_range(0, 2),
             (mode == 0) ? FlIssue : (mode == 1) ? $urandom_range(1, lat) :
             (mode == 2) ? FlBcast : (mode == 3) ? FlResp : FlNone);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsq_mem_sequencer.md
Name: lsq_mem_sequencer

Overview:
- Controller between the load/store queue head and the single data-memory port.
- Pops one ready entry at a time.
- Computes the effective address and builds byte masks and aligned store data.
- Runs one dmem transaction, then broadcasts the load result (or store completion) on the CDB with the entry's phys_rd / rob_index.
- Exactly one memory operation is outstanding at any time; flush-safe while a dmem transaction is in flight.

Parameters:
- NUM_REGS, 64, physical register count; phys-reg index width = $clog2(NUM_REGS)
- ROB_SIZE, 32, ROB depth; rob index width = $clog2(ROB_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (synchronous)
- lsq_empty  in  1  queue empty flag from LSQ
- lsq_read_enable  out  1  pop request to LSQ
- lsq_read_resp  in  1  LSQ delivered an entry (one cycle after pop)
- lsq_data  in  ld_st_queue_t  entry from LSQ
- rs1_rdata  in  32  base register value for the LSQ head's pr1
- rs2_rdata  in  32  store data for the LSQ head's pr2
- dmem_addr  out  32  word-aligned address
- dmem_rmask  out  4  read byte mask
- dmem_wmask  out  4  write byte mask
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  transaction complete
- cdb_valid  out  1  result broadcast strobe
- cdb_phys_rd  out  $clog2(NUM_REGS)  destination physical register
- cdb_rob_index  out  $clog2(ROB_SIZE)  ROB entry completed
- cdb_rdata  out  32  load result; 0 for stores
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including masks, cdb_valid and busy.
- IDLE:
  - lsq_read_enable = ~lsq_empty, combinational.
  - On lsq_read_resp=1 (including when it arrives in the same IDLE cycle): latch entry, rs1_rdata and rs2_rdata; go to ISSUE.
  - The LSQ may refuse the pop (store not at ROB head). Stay in IDLE and keep requesting.
- ISSUE (one cycle, registered outputs):
  - addr = rs1 + sext(imm), 32-bit wrap.
  - dmem_addr = {addr[31:2], 2'b00}.
  - Load masks by funct3: lb/lbu 4'b0001<<addr[1:0]; lh/lhu 4'b0011<<addr[1:0]; lw 4'b1111.
  - Stores: sb/sh/sw use the same masks, placed on wmask. wdata = rs2 << (8*addr[1:0]).
  - Exactly one of rmask/wmask is nonzero.
  - Go to WAIT.
- WAIT:
  - Hold addr/masks/wdata stable until dmem_resp.
  - On dmem_resp: zero masks. Load: extract the byte/half at addr[1:0], sign- or zero-extend per funct3 into cdb_rdata. Store: cdb_rdata=0.
  - Go to BCAST.
- BCAST: cdb_valid=1 for exactly one cycle; return to IDLE. No pop is issued in BCAST, so minimum throughput is one op per 4 cycles plus memory latency.
- Latency: pop to cdb_valid = 1 (resp) + 1 (ISSUE) + N (dmem) + 1 cycles.
- Flush:
  - In IDLE/ISSUE/BCAST: go to IDLE next cycle and suppress cdb_valid. In ISSUE, no dmem request is made.
  - In WAIT: go to DRAIN. Masks are held until dmem_resp, then cleared and the FSM returns to IDLE. No CDB broadcast.
  - A flush while in DRAIN has no additional effect.
  - A flush in the same cycle as lsq_read_resp discards the entry.
- Simultaneous dmem_resp and flush in WAIT: the transaction is complete; go to IDLE, no broadcast.
- Misaligned half/word: issued as computed. The shifted mask is truncated to 4 bits; software must not issue such accesses unless the optional feature is enabled.

Optional Feature:
- Macro LSQ_MISALIGN_TRAP_EN.
- When defined:
  - Adds output cdb_exception (1 bit).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, skips the dmem access.
  - ISSUE goes straight to BCAST with cdb_valid=1, cdb_exception=1, cdb_rdata=addr.
  - cdb_exception is 0 on all other broadcasts and on reset.
- When undefined: no port, no check; behaviour as above.

Test Plan:
- lw, rs1=0x1000, imm=8, dmem_rdata=0xDEADBEEF after 3 cycles -> dmem_addr=0x1008, rmask=4'b1111; cdb_valid once with cdb_rdata=0xDEADBEEF and the correct phys_rd/rob_index.
- lb, addr=0x1003, rdata=0x80FFFFFF -> rmask=4'b1000, cdb_rdata=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh, rs1=0x2000, imm=2, rs2=0x0000ABCD -> dmem_addr=0x2000, wmask=4'b1100, wdata=0xABCD0000, rmask=0; cdb_valid with cdb_rdata=0.
- Flush asserted 2 cycles into a 5-cycle load WAIT -> masks held until dmem_resp, then 0; no cdb_valid; next LSQ entry is popped afterwards.
- Reset asserted asynchronously mid-WAIT -> outputs 0 immediately, no clock edge required; busy=0 and lsq_read_enable follows ~lsq_empty after release.
- With LSQ_MISALIGN_TRAP_EN: lw at 0x1002 -> no dmem mask asserted; cdb_exception=1, cdb_rdata=0x00001002.
